// File: rtl/crc_stream_seq.sv
// APB4 master sequencer: programs the CRC peripheral, streams one packet of
// words into its DATA register at a fixed pace, then returns the final CRC.
module crc_stream_seq #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                WAIT_CYC  = 6
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_revin,
  input  logic              cfg_revout,
  input  logic [31:0]       cfg_init,
  input  logic [31:0]       cfg_xorv,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              res_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  input  logic              pready,
  input  logic [31:0]       prdata,
  input  logic              pslverr
);

  localparam logic [ADDR_W-1:0] A_CTRL  = BASE_ADDR + ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_INIT  = BASE_ADDR + ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_XORV  = BASE_ADDR + ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_DATA  = BASE_ADDR + ADDR_W'(32'h0C);
  localparam logic [3:0]        WAIT_LD = 4'(WAIT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, W_INIT, W_XORV, W_CLR, W_EN, D_GET, D_WR, D_WAIT, R_RES, RESP
  } state_t;

  state_t      state, state_n;
  logic        acc;
  logic [3:0]  wait_cnt;
  logic [1:0]  mode_q;
  logic        revin_q, revout_q;
  logic [31:0] init_q, xorv_q;
  logic [31:0] word_q;
  logic        last_q;
  logic        xfer_done;

  // Handshake rule: an APB transfer completes on the cycle psel&&penable&&pready
  // is high; stream words and results transfer on valid&&ready at the clock edge.
  assign xfer_done = psel && acc && pready;

  always_comb begin
    state_n   = state;
    psel      = 1'b0;
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    s_ready   = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) state_n = W_INIT;
      end
      W_INIT: begin
        psel = 1'b1; pwrite = 1'b1; paddr = A_INIT; pwdata = init_q;
        if (acc && pready) state_n = W_XORV;
      end
      W_XORV: begin
        psel = 1'b1; pwrite = 1'b1; paddr = A_XORV; pwdata = xorv_q;
        if (acc && pready) state_n = W_CLR;
      end
      W_CLR: begin
        psel = 1'b1; pwrite = 1'b1; paddr = A_CTRL;
        pwdata = {26'd0, mode_q, revout_q, revin_q, 1'b1, 1'b0};
        if (acc && pready) state_n = W_EN;
      end
      W_EN: begin
        psel = 1'b1; pwrite = 1'b1; paddr = A_CTRL;
        pwdata = {26'd0, mode_q, revout_q, revin_q, 1'b0, 1'b1};
        if (acc && pready) state_n = D_GET;
      end
      D_GET: begin
        s_ready = 1'b1;
        if (s_valid) state_n = D_WR;
      end
      D_WR: begin
        psel = 1'b1; pwrite = 1'b1; paddr = A_DATA; pwdata = word_q;
        if (acc && pready) state_n = D_WAIT;
      end
      D_WAIT: begin
        if (wait_cnt == 4'd0) state_n = last_q ? R_RES : D_GET;
      end
      R_RES: begin
        psel = 1'b1; paddr = A_DATA;
        if (acc && pready) state_n = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    penable = psel && acc;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= IDLE;
      acc      <= 1'b0;
      wait_cnt <= '0;
      mode_q   <= '0;
      revin_q  <= 1'b0;
      revout_q <= 1'b0;
      init_q   <= '0;
      xorv_q   <= '0;
      word_q   <= '0;
      last_q   <= 1'b0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      state <= state_n;
      // Setup phase lasts one cycle; access phase holds until pready.
      acc   <= psel && !(acc && pready);

      if (state == IDLE && s_valid) begin
        mode_q   <= cfg_mode;
        revin_q  <= cfg_revin;
        revout_q <= cfg_revout;
        init_q   <= cfg_init;
        xorv_q   <= cfg_xorv;
      end

      if (state == D_GET && s_valid) begin
        word_q <= s_data;
        last_q <= s_last;
      end

      if (state == D_WR && xfer_done) wait_cnt <= WAIT_LD;
      else if (state == D_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;

      if (state == R_RES && xfer_done) res_data <= prdata;

      if (xfer_done && pslverr) res_err <= 1'b1;
      else if (state == RESP && res_ready) res_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc_stream_seq.sv
// Bench for crc_stream_seq: emulates the CRC peripheral as an APB slave and
// scores the APB trace and results against a bit-serial CRC reference.
module tb_crc_stream_seq;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] BASE     = 32'h4000_0100;
  localparam int          WAIT_CYC = 6;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_INIT   = BASE + 32'h04;
  localparam logic [31:0] A_XORV   = BASE + 32'h08;
  localparam logic [31:0] A_DATA   = BASE + 32'h0C;
  localparam int          TW       = 65;

  // clock / reset
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  logic [1:0]        cfg_mode;
  logic              cfg_revin, cfg_revout;
  logic [31:0]       cfg_init, cfg_xorv;
  logic              s_valid, s_ready, s_last;
  logic [31:0]       s_data;
  logic              res_valid, res_ready, res_err;
  logic [31:0]       res_data;
  logic [ADDR_W-1:0] paddr;
  logic              psel, penable, pwrite, pready, pslverr;
  logic [31:0]       pwdata, prdata;

  crc_stream_seq #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .WAIT_CYC(WAIT_CYC)) dut (
    .pclk(pclk), .presetn(presetn),
    .cfg_mode(cfg_mode), .cfg_revin(cfg_revin), .cfg_revout(cfg_revout),
    .cfg_init(cfg_init), .cfg_xorv(cfg_xorv),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  // scoreboard state
  logic [TW-1:0] exp_q[$];
  logic [32:0]   res_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // test knobs and peripheral emulation state
  int          stall_n = 0, res_delay = 0, wcnt = 0, rcnt = 0;
  logic        err_xorv = 1'b0, spacing_on = 1'b0;
  logic [31:0] reg_ctrl = '0, reg_init = '0, reg_xorv = '0, eng_crc = '0;
  logic [31:0] pkt_w[16];
  logic [31:0] last_res = '0;
  logic        last_err = 1'b0;
  int          data_wr_cnt = 0, cyc = 0, last_data_cyc = 0;
  logic        have_last = 1'b0, prev_setup = 1'b0, prev_rv = 1'b0, prev_hs = 1'b0;
  logic [31:0] hold_addr = '0, hold_wdata = '0, prev_rdata = '0;
  logic        hold_write = 1'b0, prev_rerr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC reference: MSB-first shift register, bytes of a word taken high to low
  function automatic int width_of(input logic [1:0] m);
    return (m == 2'd0) ? 8 : ((m == 2'd3) ? 32 : 16);
  endfunction

  function automatic logic [31:0] poly_of(input logic [1:0] m);
    case (m)
      2'd0:    return 32'h07;
      2'd1:    return 32'h1021;
      2'd2:    return 32'h8005;
      default: return 32'h04C1_1DB7;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input logic [1:0] m);
    int w = width_of(m);
    if (w == 32) return 32'hFFFF_FFFF;
    return (32'h1 << w) - 32'h1;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] crc_step(input logic [1:0] m, input logic ri,
                                          input logic [31:0] crc, input logic [31:0] word);
    int w = width_of(m);
    logic [31:0] c = crc;
    logic [7:0] b;
    logic fb;
    for (int k = w/8 - 1; k >= 0; k--) begin
      b = word[8*k +: 8];
      if (ri) b = rev8(b);
      for (int i = 7; i >= 0; i--) begin
        fb = c[w-1] ^ b[i];
        c = (c << 1) & mask_of(m);
        if (fb) c = c ^ poly_of(m);
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] crc_final(input logic [1:0] m, input logic ro,
                                           input logic [31:0] xv, input logic [31:0] crc);
    int w = width_of(m);
    logic [31:0] r = crc;
    if (ro) begin
      r = '0;
      for (int i = 0; i < 32; i++) if (i < w) r[i] = crc[w-1-i];
    end
    return (r ^ xv) & mask_of(m);
  endfunction

  // APB slave: drives pready/prdata/pslverr just after each rising edge
  initial begin
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(posedge pclk); #1;
      if (psel && penable) begin
        if (wcnt < stall_n) begin
          pready = 1'b0; prdata = '0; pslverr = 1'b0; wcnt++;
        end else begin
          pready  = 1'b1;
          prdata  = (!pwrite && paddr == A_DATA) ?
                    crc_final(reg_ctrl[5:4], reg_ctrl[3], reg_xorv, eng_crc) : 32'h0;
          pslverr = err_xorv && pwrite && (paddr == A_XORV);
        end
      end else begin
        pready = 1'b0; prdata = '0; pslverr = 1'b0; wcnt = 0;
      end
    end
  end

  // result consumer
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge pclk); #1;
      if (res_valid) begin
        if (rcnt < res_delay) begin res_ready = 1'b0; rcnt++; end
        else res_ready = 1'b1;
      end else begin
        res_ready = 1'b0; rcnt = 0;
      end
    end
  end

  // compare process: samples on the falling edge
  initial begin
    logic [TW-1:0] e;
    logic [32:0]   r;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        prev_setup = 1'b0; prev_rv = 1'b0; prev_hs = 1'b0; have_last = 1'b0;
      end else begin
        cyc++;
        if (prev_setup) chk("access_follows_setup", {62'd0, psel, penable}, 64'd3);
        if (psel && !penable) begin
          hold_addr = paddr; hold_write = pwrite; hold_wdata = pwdata;
          if (pwrite && paddr == A_INIT) begin have_last = 1'b0; data_wr_cnt = 0; end
          if (pwrite && paddr == A_DATA) begin
            if (spacing_on && have_last) chk("data_spacing", 64'(cyc - last_data_cyc), 64'(WAIT_CYC + 3));
            have_last = 1'b1; last_data_cyc = cyc;
          end
        end
        if (psel && penable) begin
          chk("paddr_stable", 64'(paddr), 64'(hold_addr));
          chk("pwrite_stable", 64'(pwrite), 64'(hold_write));
          chk("pwdata_stable", 64'(pwdata), 64'(hold_wdata));
        end
        if (s_ready) chk("apb_idle_in_dget", 64'(psel), 64'd0);
        if (psel && penable && pready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_transfer: got write=%0b addr=0x%0h, expected none", pwrite, paddr);
          end else begin
            e = exp_q.pop_front();
            chk("apb_dir", 64'(pwrite), 64'(e[64]));
            chk("apb_addr", 64'(paddr), 64'(e[63:32]));
            if (pwrite) chk("apb_wdata", 64'(pwdata), 64'(e[31:0]));
          end
          if (pwrite) begin
            if (paddr == A_CTRL) begin
              reg_ctrl = pwdata;
              if (pwdata[1]) eng_crc = reg_init & mask_of(pwdata[5:4]);
            end else if (paddr == A_INIT) reg_init = pwdata;
            else if (paddr == A_XORV) reg_xorv = pwdata;
            else if (paddr == A_DATA) begin
              if (reg_ctrl[0]) eng_crc = crc_step(reg_ctrl[5:4], reg_ctrl[2], eng_crc, pwdata);
              data_wr_cnt++;
            end
          end
        end
        prev_setup = psel && !penable;

        if (prev_rv && !prev_hs) begin
          chk("res_valid_hold", 64'(res_valid), 64'd1);
          chk("res_data_hold", 64'(res_data), 64'(prev_rdata));
          chk("res_err_hold", 64'(res_err), 64'(prev_rerr));
        end
        if (res_valid && res_ready) begin
          if (res_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_result: got 0x%0h, expected none", res_data);
          end else begin
            r = res_q.pop_front();
            chk("res_data", 64'(res_data), 64'(r[31:0]));
            chk("res_err", 64'(res_err), 64'(r[32]));
          end
          last_res = res_data; last_err = res_err;
        end
        prev_rv = res_valid; prev_hs = res_valid && res_ready;
        prev_rdata = res_data; prev_rerr = res_err;
      end
    end
  end

  // driver tasks
  task automatic wait_ready();
    int t = 0;
    @(negedge pclk);
    while (!s_ready && t < 3000) begin @(negedge pclk); t++; end
    chk("s_ready_timeout", 64'(s_ready), 64'd1);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || res_q.size() != 0) && t < 5000) begin @(posedge pclk); t++; end
    chk("drain_timeout", 64'(exp_q.size() + res_q.size()), 64'd0);
    exp_q.delete(); res_q.delete();
    @(posedge pclk); #1;
  endtask

  task automatic scramble_cfg();
    cfg_mode = 2'($urandom_range(0, 3)); cfg_revin = 1'($urandom_range(0, 1));
    cfg_revout = 1'($urandom_range(0, 1)); cfg_init = $urandom(); cfg_xorv = $urandom();
  endtask

  task automatic send_packet(input logic [1:0] m, input logic ri, input logic ro,
                             input logic [31:0] ini, input logic [31:0] xv,
                             input int nw, input int gap, input logic err);
    logic [31:0] c, cb;
    cb = {26'd0, m, ro, ri, 2'b00};
    exp_q.push_back({1'b1, A_INIT, ini});
    exp_q.push_back({1'b1, A_XORV, xv});
    exp_q.push_back({1'b1, A_CTRL, cb | 32'h2});
    exp_q.push_back({1'b1, A_CTRL, cb | 32'h1});
    c = ini & mask_of(m);
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({1'b1, A_DATA, pkt_w[i]});
      c = crc_step(m, ri, c, pkt_w[i]);
    end
    exp_q.push_back({1'b0, A_DATA, 32'h0});
    res_q.push_back({err, crc_final(m, ro, xv, c)});
    err_xorv = err;
    cfg_mode = m; cfg_revin = ri; cfg_revout = ro; cfg_init = ini; cfg_xorv = xv;
    for (int i = 0; i < nw; i++) begin
      s_valid = 1'b1; s_data = pkt_w[i]; s_last = (i == nw - 1);
      wait_ready();
      @(posedge pclk); #1;
      s_valid = 1'b0; s_last = 1'b0; s_data = $urandom();
      scramble_cfg();
      if (i < nw - 1 && gap > 0) begin repeat (gap) @(posedge pclk); #1; end
    end
    wait_done();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_psel"}, 64'(psel), 64'd0);
    chk({tag, "_penable"}, 64'(penable), 64'd0);
    chk({tag, "_paddr"}, 64'(paddr), 64'd0);
    chk({tag, "_pwrite"}, 64'(pwrite), 64'd0);
    chk({tag, "_pwdata"}, 64'(pwdata), 64'd0);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_data"}, 64'(res_data), 64'd0);
    chk({tag, "_res_err"}, 64'(res_err), 64'd0);
  endtask

  task automatic load_ascii_9();
    for (int i = 0; i < 9; i++) pkt_w[i] = 32'h31 + 32'(i);
  endtask

  initial begin
    logic [31:0] c;
    int t;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    cfg_mode = '0; cfg_revin = 1'b0; cfg_revout = 1'b0; cfg_init = '0; cfg_xorv = '0;

    // model pins against published check values
    c = 32'h0;
    for (int i = 0; i < 9; i++) c = crc_step(2'd0, 1'b0, c, 32'h31 + 32'(i));
    chk("model_crc8_check", 64'(crc_final(2'd0, 1'b0, 32'h0, c)), 64'hF4);
    c = 32'hFFFF_FFFF;
    c = crc_step(2'd3, 1'b1, c, 32'h3132_3334);
    c = crc_step(2'd3, 1'b1, c, 32'h3536_3738);
    chk("model_crc32_check", 64'(crc_final(2'd3, 1'b1, 32'hFFFF_FFFF, c)), 64'h9AE0_DAAF);

    #2;
    check_outputs_zero("reset");
    repeat (3) @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;

    // CRC8 over "123456789", continuous stream, pacing checked
    load_ascii_9();
    spacing_on = 1'b1;
    send_packet(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 9, 0, 1'b0);
    spacing_on = 1'b0;
    chk("crc8_result", 64'(last_res), 64'hF4);
    chk("crc8_err", 64'(last_err), 64'd0);
    chk("crc8_data_writes", 64'(data_wr_cnt), 64'd9);

    // CRC32 over "12345678"
    pkt_w[0] = 32'h3132_3334; pkt_w[1] = 32'h3536_3738;
    send_packet(2'd3, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 1'b0);
    chk("crc32_result", 64'(last_res), 64'h9AE0_DAAF);

    // CRC16/XMODEM over "12", single word packet
    pkt_w[0] = 32'h0000_3132;
    send_packet(2'd1, 1'b0, 1'b0, 32'h0, 32'h0, 1, 0, 1'b0);
    chk("xmodem_data_writes", 64'(data_wr_cnt), 64'd1);

    // stalls everywhere: same CRC, no extra transfers
    load_ascii_9();
    stall_n = 3; res_delay = 10;
    send_packet(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 9, 5, 1'b0);
    chk("stall_result", 64'(last_res), 64'hF4);
    chk("stall_data_writes", 64'(data_wr_cnt), 64'd9);
    stall_n = 0; res_delay = 0;

    // slave error on XORV, then a clean packet
    send_packet(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 9, 0, 1'b1);
    chk("slverr_flag", 64'(last_err), 64'd1);
    chk("slverr_result", 64'(last_res), 64'hF4);
    send_packet(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 9, 0, 1'b0);
    chk("after_slverr_flag", 64'(last_err), 64'd0);

    // reset during D_WAIT of a packet, then a full packet
    err_xorv = 1'b0;
    cfg_mode = 2'd0; cfg_revin = 1'b0; cfg_revout = 1'b0; cfg_init = '0; cfg_xorv = '0;
    exp_q.push_back({1'b1, A_INIT, 32'h0});
    exp_q.push_back({1'b1, A_XORV, 32'h0});
    exp_q.push_back({1'b1, A_CTRL, 32'h2});
    exp_q.push_back({1'b1, A_CTRL, 32'h1});
    exp_q.push_back({1'b1, A_DATA, 32'h31});
    s_valid = 1'b1; s_data = 32'h31; s_last = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(posedge pclk); t++; end
    chk("reset_prefix_trace", 64'(exp_q.size()), 64'd0);
    #1; s_valid = 1'b0;
    @(posedge pclk); #3;
    presetn = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete(); res_q.delete();
    repeat (3) @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    load_ascii_9();
    send_packet(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 9, 0, 1'b0);
    chk("post_reset_result", 64'(last_res), 64'hF4);

    // randomized packets
    for (int p = 0; p < 20; p++) begin
      int nw;
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) pkt_w[i] = $urandom();
      stall_n = $urandom_range(0, 2);
      res_delay = $urandom_range(0, 3);
      send_packet(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom(), $urandom(), nw, $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_stream_seq.md
Name: crc_stream_seq

Overview:
- APB4 master sequencer that drives the CRC peripheral (CTRL/INIT/XORV/DATA/STAT) with no CPU involvement.
- Accepts per-packet configuration plus a valid/ready word stream, then runs the whole packet through the CRC engine:
  - programs the engine registers,
  - clears the engine,
  - writes each data word, pacing the writes with a fixed interval,
  - reads back the final CRC and returns it on a valid/ready result port.
- Sits between a DMA/stream source and the CRC peripheral's APB slave port.

Parameters:
ADDR_W, 32, APB address width; engine base is BASE_ADDR.
BASE_ADDR, 0, byte address of the CRC register block.
WAIT_CYC, 6, cycles from DATA write access phase to next APB transfer; legal range 6..15.

Ports:
pclk  in  1  clock
presetn  in  1  asynchronous active-low reset
cfg_mode  in  2  CRC mode written to CTRL[5:4] (0 CRC8, 1 CRC16_1021, 2 CRC16_8005, 3 CRC32)
cfg_revin  in  1  CTRL[2]
cfg_revout  in  1  CTRL[3]
cfg_init  in  32  INIT value
cfg_xorv  in  32  XORV value
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&&s_ready
s_data  in  32  input word; the engine uses the low 8/16/32 bits per mode
s_last  in  1  marks the final word of the packet
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  32  CRC read from DATA
res_err  out  1  pslverr was seen during the packet
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  32  APB write data
pready  in  1  APB ready
prdata  in  32  APB read data
pslverr  in  1  APB error

Behaviour:
- Register offsets from BASE_ADDR: CTRL 0x00, INIT 0x04, XORV 0x08, DATA 0x0C, STAT 0x10.
- CTRL layout: [0] en, [1] clr, [2] revin, [3] revout, [5:4] mode.
- Reset values: all outputs 0 and FSM in IDLE.
- APB transfers:
  - Setup phase: psel=1, penable=0, one cycle.
  - Access phase: psel=1, penable=1, held until pready.
  - Transfers are back-to-back with no idle cycle. Address, pwrite and pwdata are stable across both phases.
- IDLE:
  - s_ready=0.
  - On s_valid, sample the cfg_* inputs into internal registers (held for the whole packet) and go to W_INIT. The word is not consumed yet.
- Engine programming sequence, one APB write per state:
  - W_INIT: INIT = cfg_init.
  - W_XORV: XORV = cfg_xorv.
  - W_CLR: CTRL = {mode, revout, revin, clr=1, en=0}.
  - W_EN: CTRL = {mode, revout, revin, clr=0, en=1}.
  - Then go to D_GET.
- D_GET:
  - s_ready=1 for exactly the D_GET cycles.
  - On handshake, capture s_data and s_last, then go to D_WR.
  - If s_valid is low, stall indefinitely with APB idle.
- D_WR: APB write DATA = captured word, then go to D_WAIT.
- D_WAIT:
  - A counter loads WAIT_CYC-1 at the completion of the access phase and counts down to 0.
  - No APB activity and s_ready=0 while waiting.
  - At 0: if the captured last=0, go to D_GET; otherwise go to R_RES.
- R_RES: APB read DATA; on access completion, latch prdata into res_data, then go to RESP.
- RESP:
  - res_valid=1; hold res_data and res_err stable until res_ready.
  - On res_valid&&res_ready: clear res_valid and res_err, then go to IDLE.
  - A new packet may begin on the cycle after IDLE is entered.
- pslverr:
  - Set the sticky res_err on any access completion with pslverr=1.
  - The sequence continues unchanged; no retry.
- Single-word packet (s_last on the first word): one DATA write, then wait, then read.
- cfg_* changes mid-packet are ignored.
- s_data upper bits are passed through unmasked; the engine ignores them.
- pready held low: the FSM stalls in the access phase, all outputs stable, no timeout.
- Reset mid-operation:
  - Asynchronous return to IDLE; APB outputs drop to 0 immediately.
  - The partial packet is lost.
  - The engine is fully reprogrammed on the next packet.
- Minimum cost per word with pready=1: 1 (D_GET) + 2 (write) + WAIT_CYC cycles.
- Packet overhead: 8 cycles of configuration + 2 cycles of read + 1 result cycle.
- The STAT register is never polled; correctness relies on WAIT_CYC >= 6.

Test Plan:
- CRC8, init 0, xorv 0, no reflection; words 0x31..0x39 with s_last on 0x39 -> res_data[7:0]=0xF4, res_err=0, exactly 9 DATA writes, spaced WAIT_CYC+3 cycles apart with continuous s_valid.
- CRC32, init/xorv 0xFFFFFFFF, revin=revout=1; words 0x31323334, 0x35363738(last) -> res_data=0x9AE0DAAF.
- CRC16_1021, init 0; single word 0x00003132(last) -> res_data matches the bench model for XMODEM "12". APB trace shows INIT, XORV, CTRL=0x12, CTRL=0x11, DATA, read DATA, in that order.
- Stalls: s_valid gaps of 5 cycles between words, res_ready low for 10 cycles, pready low for 3 cycles per transfer -> same CRC as the unstalled run; signals stable during stalls; no extra transfers.
- Force pslverr on the W_XORV access -> sequence completes, res_err=1 with the result. The next packet has res_err=0.
- Assert presetn during D_WAIT of packet 1 -> outputs 0 asynchronously. Packet 2 after reset yields the correct CRC (0xF4 case).
